// File: rtl/mips_bus_mem_slave_pkg.sv
// Shared types, constants and helpers for the MIPS bus memory slave.
package mips_bus_pkg;

  typedef enum logic {
    WAIT_FIXED  = 1'b0,
    WAIT_RANDOM = 1'b1
  } wait_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } slave_state_t;

  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  lanes
  );
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_bus_mem_slave_if.sv
// Signal bundle between a MIPS bus master and the memory slave.
interface mips_bus_mem_slave_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, err, rd_count, wr_count
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, err, rd_count, wr_count
  );
endinterface

// File: rtl/mips_bus_mem_slave_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick random wait counts.
module mips_bus_lfsr16
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/mips_bus_mem_slave.sv
// Word-addressed memory slave for the MIPS bus with fixed or random wait states,
// sticky error flag and accepted-transfer counters.
module mips_bus_mem_slave
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH      = 1024,
  parameter wait_mode_t  WAIT_MODE  = WAIT_FIXED,
  parameter int unsigned FIXED_WAIT = 0,
  parameter int unsigned MAX_WAIT   = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter string       INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_bus_mem_slave_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  slave_state_t  state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic [31:0]   rd_count_q, rd_count_d;
  logic [31:0]   wr_count_q, wr_count_d;
  logic [31:0]   mem_q [DEPTH];

  logic [15:0]   lfsr_s;
  logic [4:0]    wmod_s;
  logic [3:0]    w_s;
  logic          req_s;
  logic          both_s;
  logic [31:0]   offset_s;
  logic [29:0]   word_s;
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          accept_s;
  logic          abort_s;
  logic          waitreq_s;
  logic          mem_we_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  mips_bus_lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (reset),
    .enable (1'b1),
    .seed   (LFSR_SEED),
    .state  (lfsr_s)
  );

  assign req_s      = bus.read ^ bus.write;
  assign both_s     = bus.read & bus.write;
  // Addresses below BASE_ADDR wrap to huge offsets and so fall out of range.
  assign offset_s   = bus.address - BASE_ADDR;
  assign word_s     = offset_s[31:2];
  assign idx_s      = word_s[AW-1:0];
  assign in_range_s = ({2'b00, word_s} < 32'(DEPTH)) && (bus.address[1:0] == 2'b00);

  // Five-bit modulus keeps MAX_WAIT == 15 from degenerating into a divide by zero.
  assign wmod_s   = {1'b0, lfsr_s[3:0]} % 5'(MAX_WAIT + 1);
  assign w_s      = (WAIT_MODE == WAIT_RANDOM) ? wmod_s[3:0] : 4'(FIXED_WAIT);
  assign unused_s = ^{lfsr_s[15:4], wmod_s[4], offset_s[1:0]};

  // State register, wait counter, sticky error and transfer counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wcnt_q     <= 4'd0;
      err_q      <= 1'b0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next-state logic; a dropped request in WAIT returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (req_s && (w_s != 4'd0)) begin
          wcnt_d  = w_s - 4'd1;
          state_d = WAIT;
        end else begin
          wcnt_d  = 4'd0;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!req_s || (wcnt_q == 4'd0)) begin
          state_d = IDLE;
        end else begin
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Handshake outputs: waitrequest, accept and abort strobes.
  always_comb begin
    waitreq_s = 1'b1;
    accept_s  = 1'b0;
    abort_s   = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          waitreq_s = req_s && (w_s != 4'd0);
          accept_s  = req_s && (w_s == 4'd0);
        end
        WAIT: begin
          waitreq_s = req_s && (wcnt_q != 4'd0);
          accept_s  = req_s && (wcnt_q == 4'd0);
          abort_s   = !req_s;
        end
        default: begin
          waitreq_s = 1'b0;
        end
      endcase
    end else begin
      waitreq_s = 1'b1;
    end
  end

  // Error flag and counter updates; a both-high request is never counted.
  always_comb begin
    err_d      = err_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (both_s || abort_s || (accept_s && !in_range_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    if (accept_s && bus.read) begin
      rd_count_d = rd_count_q + 32'd1;
    end else begin
      rd_count_d = rd_count_q;
    end
    if (accept_s && bus.write) begin
      wr_count_d = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  assign mem_we_s = accept_s & bus.write & in_range_s;
  assign rdata_s  = (accept_s && bus.read && in_range_s) ? mem_q[idx_s] : 32'h0000_0000;

  // Byte-lane write at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merge_lanes(mem_q[idx_s], bus.writedata, bus.byteenable);
    end
  end

  assign bus.waitrequest = waitreq_s;
  assign bus.readdata    = rdata_s;
  assign bus.err         = err_q;
  assign bus.rd_count    = rd_count_q;
  assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_mips_bus_mem_slave.sv
// Scoreboard bench: three slaves (random wait, fixed 3, fixed 0) driven with
// randomized traffic and checked against a word-array model of the memory.
module tb_mips_bus_mem_slave;
  import mips_bus_pkg::*;

  localparam int ND = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_bus_mem_slave_if bus_a ();
  mips_bus_mem_slave_if bus_b ();
  mips_bus_mem_slave_if bus_c ();

  mips_bus_mem_slave #(.BASE_ADDR(32'h0000_0000), .DEPTH(16), .WAIT_MODE(WAIT_RANDOM),
    .FIXED_WAIT(0), .MAX_WAIT(3), .LFSR_SEED(16'hACE1), .INIT_FILE(""))
    dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
  mips_bus_mem_slave #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_MODE(WAIT_FIXED),
    .FIXED_WAIT(3), .MAX_WAIT(3), .LFSR_SEED(16'hACE1), .INIT_FILE(""))
    dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));
  mips_bus_mem_slave #(.BASE_ADDR(32'h0000_0000), .DEPTH(32), .WAIT_MODE(WAIT_FIXED),
    .FIXED_WAIT(0), .MAX_WAIT(3), .LFSR_SEED(16'hACE1), .INIT_FILE(""))
    dut_c (.clk(clk), .reset(rst_n), .bus(bus_c));

  typedef struct {
    logic [31:0] data;
    int          wlo;
    int          whi;
  } exp_t;

  exp_t        q [ND][$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wc [ND];
  bit          seen_w [4];

  logic [31:0] base_m  [ND] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
  int          depth_m [ND] = '{16, 16, 32};
  int          wlo_m   [ND] = '{0, 3, 0};
  int          whi_m   [ND] = '{3, 3, 0};
  logic [31:0] mem_m   [ND][32];
  logic [31:0] rdc_m   [ND];
  logic [31:0] wrc_m   [ND];
  logic [31:0] err_m   [ND];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(int s, logic rd, logic wr, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    case (s)
      0: begin bus_a.read = rd; bus_a.write = wr; bus_a.address = a; bus_a.byteenable = be; bus_a.writedata = wd; end
      1: begin bus_b.read = rd; bus_b.write = wr; bus_b.address = a; bus_b.byteenable = be; bus_b.writedata = wd; end
      default: begin bus_c.read = rd; bus_c.write = wr; bus_c.address = a; bus_c.byteenable = be; bus_c.writedata = wd; end
    endcase
  endtask

  function automatic logic wreq(int s);
    case (s)
      0: return bus_a.waitrequest;
      1: return bus_b.waitrequest;
      default: return bus_c.waitrequest;
    endcase
  endfunction

  function automatic logic [31:0] rdata(int s);
    case (s)
      0: return bus_a.readdata;
      1: return bus_b.readdata;
      default: return bus_c.readdata;
    endcase
  endfunction

  task automatic chk_state(int s);
    logic [31:0] rc, wcv, ev;
    case (s)
      0: begin rc = bus_a.rd_count; wcv = bus_a.wr_count; ev = {31'b0, bus_a.err}; end
      1: begin rc = bus_b.rd_count; wcv = bus_b.wr_count; ev = {31'b0, bus_b.err}; end
      default: begin rc = bus_c.rd_count; wcv = bus_c.wr_count; ev = {31'b0, bus_c.err}; end
    endcase
    chk($sformatf("rd_count_dut%0d", s), rc, rdc_m[s]);
    chk($sformatf("wr_count_dut%0d", s), wcv, wrc_m[s]);
    chk($sformatf("err_dut%0d", s), ev, err_m[s]);
  endtask

  task automatic wait_accept(int s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wreq(s) && n < 40);
    if (wreq(s)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout_dut%0d: waitrequest still 1 after %0d cycles, required 0", s, n);
    end
    @(posedge clk);
    #1;
  endtask

  // Model the transfer, queue its expected response, then drive it to acceptance.
  task automatic xfer(int s, logic rd, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    exp_t        e;
    logic [31:0] idx;
    bit          inr;
    idx    = (a - base_m[s]) >> 2;
    inr    = (idx < 32'(depth_m[s])) && (a[1:0] == 2'b00);
    e.data = 32'h0;
    e.wlo  = wlo_m[s];
    e.whi  = whi_m[s];
    if (rd) begin
      if (inr) e.data = mem_m[s][idx];
      rdc_m[s] = rdc_m[s] + 32'd1;
    end else begin
      if (inr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_m[s][idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
      wrc_m[s] = wrc_m[s] + 32'd1;
    end
    if (!inr) err_m[s] = 32'd1;
    q[s].push_back(e);
    drive(s, rd, !rd, a, be, wd);
    wait_accept(s);
  endtask

  task automatic idle(int s);
    drive(s, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < ND; s++) begin
      rdc_m[s] = 32'd0;
      wrc_m[s] = 32'd0;
      err_m[s] = 32'd0;
    end
  endtask

  // Monitor: counts wait cycles of a held request and scores each accept.
  task automatic mon(int s, logic req, logic wr_v, logic [31:0] rdv);
    exp_t e;
    if (!rst_n || !req) begin
      wc[s] = 0;
    end else if (wr_v) begin
      wc[s] = wc[s] + 1;
    end else begin
      if (q[s].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_accept_dut%0d: accept seen, required none pending", s);
      end else begin
        e = q[s].pop_front();
        chk($sformatf("readdata_dut%0d", s), rdv, e.data);
        n_cmp++;
        if (wc[s] < e.wlo || wc[s] > e.whi) begin
          n_bad++;
          $display("FAIL wait_states_dut%0d: got %0d, required %0d..%0d", s, wc[s], e.wlo, e.whi);
        end
        if (s == 0 && wc[s] >= 0 && wc[s] <= 3) seen_w[wc[s]] = 1'b1;
      end
      wc[s] = 0;
    end
  endtask

  always @(negedge clk) mon(0, bus_a.read ^ bus_a.write, bus_a.waitrequest, bus_a.readdata);
  always @(negedge clk) mon(1, bus_b.read ^ bus_b.write, bus_b.waitrequest, bus_b.readdata);
  always @(negedge clk) mon(2, bus_c.read ^ bus_c.write, bus_c.waitrequest, bus_c.readdata);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int s = 0; s < ND; s++) begin
      idle(s);
      wc[s] = 0;
    end
    model_reset();

    // Values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < ND; s++) begin
      chk($sformatf("reset_waitreq_dut%0d", s), 32'(wreq(s)), 32'd1);
      chk($sformatf("reset_readdata_dut%0d", s), rdata(s), 32'h0);
      chk_state(s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word through the bus so the model knows all contents.
    for (int s = 0; s < ND; s++) begin
      for (int i = 0; i < depth_m[s]; i++) begin
        xfer(s, 1'b0, base_m[s] + 32'(4 * i), 4'hF, (s == 2 && i == 0) ? 32'h0022_1820 : $urandom);
      end
      idle(s);
      chk_state(s);
    end

    // Zero-wait read returns data in the request cycle.
    xfer(2, 1'b1, 32'h0, 4'h0, 32'h0);
    idle(2);
    chk_state(2);

    // Three-wait partial write of the low half-word, then read back.
    xfer(1, 1'b0, 32'h0000_1004, 4'b0011, 32'hAC01_0000);
    idle(1);
    chk_state(1);
    xfer(1, 1'b1, 32'h0000_1004, 4'h0, 32'h0);
    idle(1);

    // Random back-to-back traffic with random waits on dut_a.
    for (int i = 0; i < 320; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 32'(64 + $urandom_range(0, 7) * 4);
      else             a = 32'($urandom_range(0, 15) * 4);
      xfer(0, (i % 3) != 2, a, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle(0);
        @(posedge clk);
        #1;
      end
    end
    idle(0);
    chk_state(0);
    for (int v = 0; v < 4; v++) chk($sformatf("wait_value_%0d_seen", v), 32'(seen_w[v]), 32'd1);

    // Misaligned and past-the-end accesses on dut_c.
    xfer(2, 1'b1, 32'h0000_0002, 4'h0, 32'h0);
    xfer(2, 1'b1, 32'h0000_0080, 4'h0, 32'h0);
    xfer(2, 1'b0, 32'h0000_0002, 4'hF, 32'hDEAD_BEEF);
    xfer(2, 1'b1, 32'h0000_0000, 4'h0, 32'h0);
    idle(2);
    chk_state(2);

    // read and write together: accepted at once with no effect.
    drive(1, 1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678);
    @(negedge clk);
    chk("both_waitreq", 32'(wreq(1)), 32'd0);
    chk("both_readdata", rdata(1), 32'h0);
    @(posedge clk);
    #1;
    idle(1);
    err_m[1] = 32'd1;
    chk_state(1);
    xfer(1, 1'b1, 32'h0000_1000, 4'h0, 32'h0);
    idle(1);

    // Reset in the middle of a waiting write leaves the word untouched.
    drive(1, 1'b0, 1'b1, 32'h0000_1008, 4'hF, 32'h5A5A_5A5A);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_waitreq", 32'(wreq(1)), 32'd1);
    chk("midreset_readdata", rdata(1), 32'h0);
    idle(1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < ND; s++) chk_state(s);
    xfer(1, 1'b1, 32'h0000_1008, 4'h0, 32'h0);
    idle(1);
    chk_state(1);

    // Read dropped after one wait cycle is aborted.
    drive(1, 1'b1, 1'b0, 32'h0000_100C, 4'h0, 32'h0);
    @(negedge clk);
    chk("abort_waitreq", 32'(wreq(1)), 32'd1);
    @(posedge clk);
    #1;
    idle(1);
    @(posedge clk);
    #1;
    err_m[1] = 32'd1;
    chk_state(1);

    for (int s = 0; s < ND; s++) begin
      chk_state(s);
      chk($sformatf("pending_dut%0d", s), 32'(q[s].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
